// File: rtl/div_requester.sv
// rtl/div_requester.sv - Divide request sequencer: operand prep, core handshake, sign fix, writeback.
// Optional macro DIV_RESULT_REUSE_EN keeps the last core result and replays it for repeated operands.
module div_requester #(
    parameter int DIV_WIDTH = 32,
    parameter int ID_W = 3,
    localparam int CLZ_W = $clog2(DIV_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [DIV_WIDTH-1:0] issue_rs1,
    input  logic [DIV_WIDTH-1:0] issue_rs2,
    input  logic [1:0]           issue_op,
    input  logic [ID_W-1:0]      issue_id,
    output logic                 div_start,
    output logic [DIV_WIDTH-1:0] div_dividend,
    output logic [DIV_WIDTH-1:0] div_divisor,
    output logic [CLZ_W-1:0]     div_dividend_CLZ,
    output logic [CLZ_W-1:0]     div_divisor_CLZ,
    input  logic                 div_done,
    input  logic [DIV_WIDTH-1:0] div_quotient,
    input  logic [DIV_WIDTH-1:0] div_remainder,
    output logic                 wb_valid,
    input  logic                 wb_ack,
    output logic [DIV_WIDTH-1:0] wb_data,
    output logic [ID_W-1:0]      wb_id
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        CAPTURE,
        RESULT
    } state_t;

    state_t state, state_next;

    logic                 accept;
    logic                 in_signed;
    logic                 in_neg1;
    logic                 in_neg2;
    logic                 div_by_zero;
    logic                 reuse_hit;
    logic [DIV_WIDTH-1:0] in_mag1;
    logic [DIV_WIDTH-1:0] in_mag2;
    logic [DIV_WIDTH-1:0] bypass_data;
    logic [DIV_WIDTH-1:0] quot_fix;
    logic [DIV_WIDTH-1:0] rem_fix;

    logic [1:0]           op_q;
    logic [ID_W-1:0]      id_q;
    logic                 neg1_q;
    logic                 neg2_q;
    logic [DIV_WIDTH-1:0] mag1_q;
    logic [DIV_WIDTH-1:0] mag2_q;
    logic [CLZ_W-1:0]     clz1_q;
    logic [CLZ_W-1:0]     clz2_q;
    logic [DIV_WIDTH-1:0] wb_data_q;

    // Zero saturates to DIV_WIDTH-1 so the count always fits in CLZ_W bits.
    function automatic logic [CLZ_W-1:0] clz(input logic [DIV_WIDTH-1:0] v);
        logic [CLZ_W-1:0] n;
        logic             found;
        n     = CLZ_W'(DIV_WIDTH - 1);
        found = 1'b0;
        for (int i = DIV_WIDTH - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = CLZ_W'(DIV_WIDTH - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    assign accept      = (state == IDLE) && issue_valid;
    assign in_signed   = ~issue_op[0];
    assign in_neg1     = in_signed & issue_rs1[DIV_WIDTH-1];
    assign in_neg2     = in_signed & issue_rs2[DIV_WIDTH-1];
    assign in_mag1     = in_neg1 ? -issue_rs1 : issue_rs1;
    assign in_mag2     = in_neg2 ? -issue_rs2 : issue_rs2;
    assign div_by_zero = (issue_rs2 == '0);

    // Both corrections are formed for every signed op so the reuse store holds each one.
    assign quot_fix = (neg1_q ^ neg2_q) ? -div_quotient : div_quotient;
    assign rem_fix  = neg1_q ? -div_remainder : div_remainder;

`ifdef DIV_RESULT_REUSE_EN
    logic                 reuse_valid;
    logic                 st_signed;
    logic                 st_neg1;
    logic                 st_neg2;
    logic [DIV_WIDTH-1:0] st_mag1;
    logic [DIV_WIDTH-1:0] st_mag2;
    logic [DIV_WIDTH-1:0] st_quot;
    logic [DIV_WIDTH-1:0] st_rem;

    assign reuse_hit = reuse_valid && (st_signed == in_signed) &&
                       (st_neg1 == in_neg1) && (st_neg2 == in_neg2) &&
                       (st_mag1 == in_mag1) && (st_mag2 == in_mag2);

    assign bypass_data = div_by_zero ? (issue_op[1] ? issue_rs1 : '1)
                                     : (issue_op[1] ? st_rem : st_quot);

    always_ff @(posedge clk) begin
        if (!rst) begin
            reuse_valid <= 1'b0;
        end else if (state == CAPTURE) begin
            reuse_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == CAPTURE) begin
            st_signed <= ~op_q[0];
            st_neg1   <= neg1_q;
            st_neg2   <= neg2_q;
            st_mag1   <= mag1_q;
            st_mag2   <= mag2_q;
            st_quot   <= quot_fix;
            st_rem    <= rem_fix;
        end
    end
`else
    assign reuse_hit   = 1'b0;
    assign bypass_data = issue_op[1] ? issue_rs1 : '1;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        issue_ready = 1'b0;
        div_start   = 1'b0;
        wb_valid    = 1'b0;
        case (state)
            IDLE: begin
                issue_ready = 1'b1;
                if (issue_valid) begin
                    state_next = (div_by_zero || reuse_hit) ? RESULT : START;
                end
            end
            START: begin
                div_start  = 1'b1;
                state_next = div_done ? CAPTURE : WAIT;
            end
            WAIT: begin
                if (div_done) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next = RESULT;
            end
            RESULT: begin
                wb_valid = 1'b1;
                if (wb_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand registers change only on accept, which keeps the core inputs stable while busy.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q      <= issue_op;
            id_q      <= issue_id;
            neg1_q    <= in_neg1;
            neg2_q    <= in_neg2;
            mag1_q    <= in_mag1;
            mag2_q    <= in_mag2;
            clz1_q    <= clz(in_mag1);
            clz2_q    <= clz(in_mag2);
            wb_data_q <= bypass_data;
        end else if (state == CAPTURE) begin
            wb_data_q <= op_q[1] ? rem_fix : quot_fix;
        end
    end

    assign div_dividend     = mag1_q;
    assign div_divisor      = mag2_q;
    assign div_dividend_CLZ = clz1_q;
    assign div_divisor_CLZ  = clz2_q;
    assign wb_data          = wb_data_q;
    assign wb_id            = id_q;

endmodule
